// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared types and entry layout for the sprite line engine
// Purpose: sprite table entry field offsets/widths, the per-line slot record
// and the scan FSM state encoding. Slot field widths track the default build
// of sprite_line_engine (8 sprites, 12-bit x, 256-row sprites).
package ppu_pkg;

    localparam int CHAR_W    = 8;
    localparam int PKG_X_W   = 12;
    localparam int PKG_IDX_W = 3;
    localparam int PKG_DY_W  = 8;

    // Entry layout is {char, y, x} with x in the LSBs.
    function automatic int entry_y_lsb(input int x_w);
        return x_w;
    endfunction

    function automatic int entry_char_lsb(input int x_w, input int y_w);
        return x_w + y_w;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [PKG_IDX_W-1:0] idx;
        logic [PKG_X_W-1:0]   x;
        logic [CHAR_W-1:0]    chr;
        logic [PKG_DY_W-1:0]  dy;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COPY
    } state_t;

endpackage

// File: rtl/sprite_slot_match.sv
// rtl/sprite_slot_match.sv - x-range compare and tile-relative column for one slot
// Purpose: decides whether the current pixel column falls inside one sprite slot.
// Ports: i_valid/i_slot_x/i_mirror describe the slot, i_pix_x is the pixel column,
//        o_match flags coverage, o_rel_x is the column inside the sprite.
// Optional feature: SPRITE_MIRROR_EN enables horizontal mirroring via i_mirror.
module sprite_slot_match #(
    parameter int X_W   = 12,
    parameter int SPR_W = 64
) (
    input  logic                     i_valid,
    input  logic [X_W-1:0]           i_slot_x,
    input  logic                     i_mirror,
    input  logic [X_W-1:0]           i_pix_x,
    output logic                     o_match,
    output logic [$clog2(SPR_W)-1:0] o_rel_x
);
    localparam int RX_W = $clog2(SPR_W);

    logic [X_W:0] w_dx;

    // One extra bit so a pixel left of the sprite shows as negative instead of wrapping.
    assign w_dx    = {1'b0, i_pix_x} - {1'b0, i_slot_x};
    assign o_match = i_valid && !w_dx[X_W] && (w_dx < (X_W+1)'(SPR_W));

`ifdef SPRITE_MIRROR_EN
    // SPR_W is a power of two, so SPR_W-1-d is the bitwise inverse of d.
    assign o_rel_x = i_mirror ? ~w_dx[RX_W-1:0] : w_dx[RX_W-1:0];
`else
    logic w_unused_mirror;
    assign w_unused_mirror = i_mirror;
    assign o_rel_x         = w_dx[RX_W-1:0];
`endif

endmodule

// File: rtl/sprite_line_engine.sv
// rtl/sprite_line_engine.sv - per-scanline sprite evaluation and pixel-hit engine
// Purpose: double-buffered sprite table, hblank scan into SLOTS line slots,
// per-pixel winner selection with one register stage.
// Ports: wr_en/wr_addr/wr_data write the shadow table, frame_start commits it,
//        line_start/eval_row start a scan, pix_x drives the pixel lookup;
//        busy, overflow, hit, spr_idx, spr_char, rel_x, rel_y are registered outputs.
// Optional feature: SPRITE_MIRROR_EN treats char[7] as a horizontal-mirror flag.
module sprite_line_engine
    import ppu_pkg::*;
#(
    parameter int NUM_SPRITES = 8,
    parameter int SLOTS       = 4,
    parameter int X_W         = 12,
    parameter int Y_W         = 11,
    parameter int SPR_W       = 64,
    parameter int SPR_H       = 256
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_SPRITES)-1:0] wr_addr,
    input  logic [X_W+Y_W+8-1:0]           wr_data,
    input  logic                           frame_start,
    input  logic                           line_start,
    input  logic [Y_W-1:0]                 eval_row,
    input  logic [X_W-1:0]                 pix_x,
    output logic                           busy,
    output logic                           overflow,
    output logic                           hit,
    output logic [$clog2(NUM_SPRITES)-1:0] spr_idx,
    output logic [7:0]                     spr_char,
    output logic [$clog2(SPR_W)-1:0]       rel_x,
    output logic [$clog2(SPR_H)-1:0]       rel_y
);
    localparam int IDX_W   = $clog2(NUM_SPRITES);
    localparam int RX_W    = $clog2(SPR_W);
    localparam int RY_W    = $clog2(SPR_H);
    localparam int ENTRY_W = X_W + Y_W + 8;
    localparam int CNT_W   = $clog2(SLOTS + 1);
    localparam int Y_LSB   = entry_y_lsb(X_W);
    localparam int C_LSB   = entry_char_lsb(X_W, Y_W);

    logic [ENTRY_W-1:0] r_shadow [NUM_SPRITES];
    logic [ENTRY_W-1:0] r_active [NUM_SPRITES];

    state_t             r_state;
    logic [Y_W-1:0]     r_row;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    slot_t              r_pend  [SLOTS];
    slot_t              r_slots [SLOTS];

    logic [ENTRY_W-1:0] w_ent;
    logic [Y_W:0]       w_dy;
    logic               w_row_hit;
    slot_t              w_new;
    logic [SLOTS-1:0]   w_match;
    logic [RX_W-1:0]    w_rel_x [SLOTS];
    slot_t              w_sel;
    logic [RX_W-1:0]    w_sel_rx;

    // A commit reads the shadow before a same-cycle write lands, so that write waits a frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (wr_en)
                r_shadow[wr_addr] <= wr_data;
            if (frame_start)
                for (int i = 0; i < NUM_SPRITES; i++)
                    r_active[i] <= r_shadow[i];
        end
    end

    always_comb begin
        w_ent     = r_active[r_idx];
        w_dy      = {1'b0, r_row} - {1'b0, w_ent[Y_LSB +: Y_W]};
        w_row_hit = !w_dy[Y_W] && (w_dy < (Y_W+1)'(SPR_H));
        w_new       = '0;
        w_new.valid = 1'b1;
        w_new.idx   = r_idx;
        w_new.x     = w_ent[X_W-1:0];
        w_new.chr   = w_ent[C_LSB +: 8];
        w_new.dy    = w_dy[RY_W-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_row    <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            for (int s = 0; s < SLOTS; s++) begin
                r_pend[s]  <= '0;
                r_slots[s] <= '0;
            end
        end else begin
            if (frame_start)
                overflow <= 1'b0;
            if (r_state != IDLE && frame_start) begin
                r_state <= IDLE;
                busy    <= 1'b0;
                for (int s = 0; s < SLOTS; s++)
                    r_slots[s] <= '0;
            end else if (line_start) begin
                // Also covers a restart mid-scan; the active slot bank is left alone.
                r_state <= SCAN;
                busy    <= 1'b1;
                r_row   <= eval_row;
                r_idx   <= '0;
                r_cnt   <= '0;
                for (int s = 0; s < SLOTS; s++)
                    r_pend[s] <= '0;
            end else begin
                case (r_state)
                    SCAN: begin
                        if (w_row_hit) begin
                            if (r_cnt == CNT_W'(SLOTS)) begin
                                overflow <= 1'b1;
                            end else begin
                                for (int s = 0; s < SLOTS; s++)
                                    if (r_cnt == CNT_W'(s))
                                        r_pend[s] <= w_new;
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        if (r_idx == IDX_W'(NUM_SPRITES - 1))
                            r_state <= COPY;
                        else
                            r_idx <= r_idx + 1'b1;
                    end
                    COPY: begin
                        for (int s = 0; s < SLOTS; s++)
                            r_slots[s] <= r_pend[s];
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        sprite_slot_match #(
            .X_W   (X_W),
            .SPR_W (SPR_W)
        ) u_match (
            .i_valid  (r_slots[s].valid),
            .i_slot_x (r_slots[s].x),
            .i_mirror (r_slots[s].chr[7]),
            .i_pix_x  (pix_x),
            .o_match  (w_match[s]),
            .o_rel_x  (w_rel_x[s])
        );
    end

    // Walk from the top slot down so the lowest matching slot is the last assignment.
    always_comb begin
        w_sel    = '0;
        w_sel_rx = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (w_match[s]) begin
                w_sel    = r_slots[s];
                w_sel_rx = w_rel_x[s];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit      <= 1'b0;
            spr_idx  <= '0;
            spr_char <= '0;
            rel_x    <= '0;
            rel_y    <= '0;
        end else begin
            hit      <= w_sel.valid;
            spr_idx  <= w_sel.idx;
`ifdef SPRITE_MIRROR_EN
            spr_char <= {1'b0, w_sel.chr[6:0]};
`else
            spr_char <= w_sel.chr;
`endif
            rel_x    <= w_sel_rx;
            rel_y    <= w_sel.dy;
        end
    end

endmodule

// File: tb/tb_sprite_line_engine.sv
// tb/tb_sprite_line_engine.sv - self-checking bench for sprite_line_engine
module tb_sprite_line_engine;
    localparam int NS = 8;
    localparam int SL = 4;
    localparam int SW = 64;
    localparam int SH = 256;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [30:0] wr_data = '0;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic [10:0] eval_row = '0;
    logic [11:0] pix_x = '0;
    logic        busy, overflow, hit;
    logic [2:0]  spr_idx;
    logic [7:0]  spr_char;
    logic [5:0]  rel_x;
    logic [7:0]  rel_y;

    int checks = 0;
    int failures = 0;

    int m_sh_x[NS], m_sh_y[NS], m_sh_c[NS];
    int m_ac_x[NS], m_ac_y[NS], m_ac_c[NS];
    int m_sl_n = 0;
    int m_sl_idx[SL], m_sl_x[SL], m_sl_c[SL], m_sl_dy[SL];
    int m_ovf = 0;

    sprite_line_engine dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_start(frame_start), .line_start(line_start), .eval_row(eval_row), .pix_x(pix_x),
        .busy(busy), .overflow(overflow), .hit(hit), .spr_idx(spr_idx), .spr_char(spr_char),
        .rel_x(rel_x), .rel_y(rel_y)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [30:0] pack(input int x, input int y, input int c);
        return {8'(c), 11'(y), 12'(x)};
    endfunction

    function automatic void model_commit();
        for (int i = 0; i < NS; i++) begin
            m_ac_x[i] = m_sh_x[i];
            m_ac_y[i] = m_sh_y[i];
            m_ac_c[i] = m_sh_c[i];
        end
        m_ovf = 0;
    endfunction

    // Slots are the first SL table entries (ascending index) whose row span covers row.
    function automatic void model_scan(input int row);
        m_sl_n = 0;
        for (int i = 0; i < NS; i++) begin
            int d;
            d = row - m_ac_y[i];
            if (d >= 0 && d < SH) begin
                if (m_sl_n < SL) begin
                    m_sl_idx[m_sl_n] = i;
                    m_sl_x[m_sl_n]   = m_ac_x[i];
                    m_sl_c[m_sl_n]   = m_ac_c[i];
                    m_sl_dy[m_sl_n]  = d;
                    m_sl_n++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endfunction

    function automatic logic [25:0] model_pix(input int p);
        for (int s = 0; s < m_sl_n; s++) begin
            int d, rx, ch;
            d = p - m_sl_x[s];
            if (d >= 0 && d < SW) begin
                rx = d;
                ch = m_sl_c[s];
`ifdef SPRITE_MIRROR_EN
                if (ch >= 128) rx = SW - 1 - d;
                ch = ch % 128;
`endif
                return {1'b1, 3'(m_sl_idx[s]), 8'(ch), 6'(rx), 8'(m_sl_dy[s])};
            end
        end
        return '0;
    endfunction

    task automatic wr(input int i, input int x, input int y, input int c);
        wr_en = 1'b1;
        wr_addr = 3'(i);
        wr_data = pack(x, y, c);
        tick();
        wr_en = 1'b0;
        m_sh_x[i] = x; m_sh_y[i] = y; m_sh_c[i] = c;
    endtask

    task automatic commit();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        model_commit();
    endtask

    task automatic park_all();
        for (int i = 0; i < NS; i++) wr(i, 0, 2000, 0);
    endtask

    task automatic run_scan(input int row, output int first_busy, output int busy_cycles);
        eval_row = 11'(row);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        first_busy = int'(busy);
        busy_cycles = 0;
        while (busy && busy_cycles < 200) begin
            busy_cycles++;
            tick();
        end
        model_scan(row);
    endtask

    task automatic probe(input int p, output logic [25:0] got);
        pix_x = 12'(p);
        tick();
        got = {hit, spr_idx, spr_char, rel_x, rel_y};
    endtask

    task automatic test_reset();
        logic [25:0] got;
        for (int i = 0; i < NS; i++) begin
            m_sh_x[i] = 0; m_sh_y[i] = 0; m_sh_c[i] = 0;
            m_ac_x[i] = 0; m_ac_y[i] = 0; m_ac_c[i] = 0;
        end
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, overflow, hit, spr_idx, spr_char, rel_x, rel_y} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {busy, overflow, hit, spr_idx, spr_char, rel_x, rel_y});
        end
        reset = 1'b0;
        probe(0, got);
        checks++;
        if (got !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_pixel got=%h busy=%b exp=0", got, busy);
        end
    endtask

    task automatic test_basic_hit();
        int fb, bc;
        logic [25:0] got;
        park_all();
        wr(0, 200, 100, 8'h05);
        commit();
        run_scan(110, fb, bc);
        checks++;
        if (fb != 1 || bc != NS + 1) begin
            failures++;
            $display("FAIL scan_busy first=%0d cycles=%0d exp first=1 cycles=%0d", fb, bc, NS + 1);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL basic_overflow got=%b exp=0", overflow);
        end
        probe(200, got);
        checks++;
        if (got !== {1'b1, 3'd0, 8'h05, 6'd0, 8'd10}) begin
            failures++;
            $display("FAIL basic_left_edge got=%h exp=%h", got, {1'b1, 3'd0, 8'h05, 6'd0, 8'd10});
        end
        probe(263, got);
        checks++;
        if (got !== {1'b1, 3'd0, 8'h05, 6'd63, 8'd10}) begin
            failures++;
            $display("FAIL basic_right_edge got=%h exp=%h", got, {1'b1, 3'd0, 8'h05, 6'd63, 8'd10});
        end
        for (int p = 190; p <= 270; p++) begin
            probe(p, got);
            checks++;
            if (got !== model_pix(p)) begin
                failures++;
                $display("FAIL basic_sweep pix=%0d got=%h exp=%h", p, got, model_pix(p));
            end
        end
    endtask

    task automatic test_priority();
        int fb, bc;
        logic [25:0] got;
        park_all();
        wr(1, 300, 40, 8'h11);
        wr(3, 280, 0, 8'h33);
        commit();
        run_scan(50, fb, bc);
        probe(300, got);
        checks++;
        if (got !== {1'b1, 3'd1, 8'h11, 6'd0, 8'd10}) begin
            failures++;
            $display("FAIL priority_overlap got=%h exp=%h", got, {1'b1, 3'd1, 8'h11, 6'd0, 8'd10});
        end
        probe(290, got);
        checks++;
        if (got !== {1'b1, 3'd3, 8'h33, 6'd10, 8'd50}) begin
            failures++;
            $display("FAIL priority_single got=%h exp=%h", got, {1'b1, 3'd3, 8'h33, 6'd10, 8'd50});
        end
        for (int p = 270; p <= 370; p += 3) begin
            probe(p, got);
            checks++;
            if (got !== model_pix(p)) begin
                failures++;
                $display("FAIL priority_sweep pix=%0d got=%h exp=%h", p, got, model_pix(p));
            end
        end
    endtask

    task automatic test_overflow();
        int fb, bc;
        logic [25:0] got, exp;
        park_all();
        for (int i = 0; i <= SL; i++) wr(i, 100 * i + 50, 20 - i, i + 1);
        commit();
        run_scan(20, fb, bc);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set got=%b exp=1", overflow);
        end
        for (int i = 0; i <= SL; i++) begin
            probe(100 * i + 60, got);
            exp = (i < SL) ? {1'b1, 3'(i), 8'(i + 1), 6'd10, 8'(i)} : 26'd0;
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL overflow_slot entry=%0d got=%h exp=%h", i, got, exp);
            end
        end
        commit();
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear got=%b exp=0", overflow);
        end
    endtask

    task automatic test_commit_hazard();
        int fb, bc;
        logic [25:0] got;
        park_all();
        wr(0, 500, 300, 8'h21);
        commit();
        wr_en = 1'b1;
        wr_addr = 3'd0;
        wr_data = pack(700, 300, 8'h32);
        frame_start = 1'b1;
        tick();
        wr_en = 1'b0;
        frame_start = 1'b0;
        model_commit();
        m_sh_x[0] = 700; m_sh_y[0] = 300; m_sh_c[0] = 8'h32;
        run_scan(305, fb, bc);
        probe(510, got);
        checks++;
        if (got !== {1'b1, 3'd0, 8'h21, 6'd10, 8'd5}) begin
            failures++;
            $display("FAIL hazard_old got=%h exp=%h", got, {1'b1, 3'd0, 8'h21, 6'd10, 8'd5});
        end
        probe(710, got);
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL hazard_new_early got=%h exp=0", got);
        end
        commit();
        run_scan(305, fb, bc);
        probe(710, got);
        checks++;
        if (got !== {1'b1, 3'd0, 8'h32, 6'd10, 8'd5}) begin
            failures++;
            $display("FAIL hazard_new got=%h exp=%h", got, {1'b1, 3'd0, 8'h32, 6'd10, 8'd5});
        end
    endtask

    task automatic test_boundary();
        int fb, bc;
        logic [25:0] got;
        park_all();
        wr(0, 100, 0, 8'h07);
        wr(1, 4064, 1000, 8'h09);
        commit();
        run_scan(SH - 1, fb, bc);
        probe(100, got);
        checks++;
        if (got !== {1'b1, 3'd0, 8'h07, 6'd0, 8'd255}) begin
            failures++;
            $display("FAIL boundary_last_row got=%h exp=%h", got, {1'b1, 3'd0, 8'h07, 6'd0, 8'd255});
        end
        run_scan(SH, fb, bc);
        probe(100, got);
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL boundary_past_row got=%h exp=0", got);
        end
        run_scan(1000, fb, bc);
        probe(0, got);
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL boundary_no_wrap got=%h exp=0", got);
        end
        probe(4095, got);
        checks++;
        if (got !== {1'b1, 3'd1, 8'h09, 6'd31, 8'd0}) begin
            failures++;
            $display("FAIL boundary_right got=%h exp=%h", got, {1'b1, 3'd1, 8'h09, 6'd31, 8'd0});
        end
    endtask

    task automatic test_back_to_back();
        int bc;
        logic [25:0] got;
        park_all();
        wr(2, 400, 100, 8'h12);
        wr(5, 800, 500, 8'h15);
        commit();
        eval_row = 11'd150;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick();
        tick();
        eval_row = 11'd550;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        bc = 0;
        while (busy && bc < 200) begin
            bc++;
            tick();
        end
        model_scan(550);
        checks++;
        if (bc != NS + 1) begin
            failures++;
            $display("FAIL restart_busy cycles=%0d exp=%0d", bc, NS + 1);
        end
        probe(810, got);
        checks++;
        if (got !== {1'b1, 3'd5, 8'h15, 6'd10, 8'd50}) begin
            failures++;
            $display("FAIL restart_row got=%h exp=%h", got, {1'b1, 3'd5, 8'h15, 6'd10, 8'd50});
        end
        probe(410, got);
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL restart_stale got=%h exp=0", got);
        end
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        model_commit();
        m_sl_n = 0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy got=%b exp=0", busy);
        end
        probe(810, got);
        checks++;
        if (got !== model_pix(810)) begin
            failures++;
            $display("FAIL abort_slots got=%h exp=%h", got, model_pix(810));
        end
    endtask

    task automatic test_random();
        int fb, bc, row, s, p;
        logic [25:0] got;
        for (int it = 0; it < 16; it++) begin
            for (int k = 0; k < 4; k++)
                wr($urandom_range(0, NS - 1), $urandom_range(0, 4095),
                   $urandom_range(0, 700), $urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) commit();
            row = $urandom_range(0, 700);
            run_scan(row, fb, bc);
            checks++;
            if (int'(overflow) != m_ovf || bc != NS + 1) begin
                failures++;
                $display("FAIL random_scan it=%0d ovf=%b exp=%0d cycles=%0d", it, overflow, m_ovf, bc);
            end
            for (int k = 0; k < 12; k++) begin
                if (m_sl_n > 0 && $urandom_range(0, 3) != 0) begin
                    s = $urandom_range(0, m_sl_n - 1);
                    p = (m_sl_x[s] + $urandom_range(0, 70) - 3) % 4096;
                    if (p < 0) p += 4096;
                end else begin
                    p = $urandom_range(0, 4095);
                end
                probe(p, got);
                checks++;
                if (got !== model_pix(p)) begin
                    failures++;
                    $display("FAIL random_pix it=%0d pix=%0d got=%h exp=%h", it, p, got, model_pix(p));
                end
            end
        end
    endtask

`ifdef SPRITE_MIRROR_EN
    task automatic test_mirror();
        int fb, bc;
        logic [25:0] got;
        park_all();
        wr(0, 200, 100, 8'h85);
        commit();
        run_scan(100, fb, bc);
        probe(200, got);
        checks++;
        if (got !== {1'b1, 3'd0, 8'h05, 6'd63, 8'd0}) begin
            failures++;
            $display("FAIL mirror got=%h exp=%h", got, {1'b1, 3'd0, 8'h05, 6'd63, 8'd0});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_hit();
        test_priority();
        test_overflow();
        test_commit_hazard();
        test_boundary();
        test_back_to_back();
`ifdef SPRITE_MIRROR_EN
        test_mirror();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_line_engine.md
# sprite_line_engine

Parametrised per-scanline sprite evaluation and pixel-hit engine for the picture processing unit. It is the successor to the two-hardwired-sprite compare logic. The engine holds a double-buffered table of NUM_SPRITES entries written by the game state machine. During horizontal blank it scans the table for sprites that overlap the next row, keeping up to SLOTS of them. During the visible line it resolves the winning sprite per pixel and emits its tile-relative coordinates, which feed the moving-sprite pattern memory.

## Interface
Parameters:
- NUM_SPRITES, 8: sprite table depth; power of two, 2..64.
- SLOTS, 4: maximum sprites rendered per line; 1..NUM_SPRITES.
- X_W, 12: screen x coordinate width.
- Y_W, 11: screen y coordinate width.
- SPR_W, 64: sprite width in pixels; power of two.
- SPR_H, 256: sprite height in pixels; power of two.
- Derived: ENTRY_W = X_W+Y_W+8. The entry layout is {char[7:0], y[Y_W-1:0], x[X_W-1:0]}, with char in the MSBs and x in the LSBs.

Ports:
- clock, in, 1: single clock.
- reset, in, 1: asynchronous, active-high.
- wr_en, in, 1: write one shadow table entry.
- wr_addr, in, log2(NUM_SPRITES): entry index.
- wr_data, in, ENTRY_W: entry contents.
- frame_start, in, 1: one-cycle pulse that commits the shadow table to the active table.
- line_start, in, 1: one-cycle pulse at the start of hblank; starts a scan.
- eval_row, in, Y_W: row to evaluate; sampled on line_start.
- pix_x, in, X_W: current pixel column.
- busy, out, 1: scan in progress.
- overflow, out, 1: sticky flag; more than SLOTS hits occurred on some line this frame.
- hit, out, 1: a sprite covers pix_x on the current row.
- spr_idx, out, log2(NUM_SPRITES): table index of the winning sprite.
- spr_char, out, 8: char byte of the winning sprite.
- rel_x, out, log2(SPR_W): column within the sprite.
- rel_y, out, log2(SPR_H): row within the sprite.

## Operation
- Shadow table: wr_en writes shadow[wr_addr] on the next edge. Writes are accepted at any time. Writes are never read directly by the scan.
- Commit: on frame_start, active is loaded from shadow. If wr_en is asserted in the same cycle, the commit copies the pre-write shadow contents, and the write lands for the next frame. frame_start also clears overflow.
- FSM states:
  - IDLE: line_start latches eval_row, clears the pending bank and index, then goes to SCAN.
  - SCAN: examines active[idx], one entry per cycle, for idx = 0..NUM_SPRITES-1.
  - COPY: the pending bank becomes the active slot bank; return to IDLE.
- Hit test: (eval_row - y) is computed in Y_W+1 bits. The entry hits if the result is non-negative and less than SPR_H.
- On a hit, the entry fills the next free pending slot, storing idx, x, char and dy = eval_row - y. The dy value is truncated to log2(SPR_H) bits.
- A hit with all slots full sets overflow. That entry is dropped.
- Slots fill in ascending table index.
- line_start during SCAN or COPY restarts the scan with the new eval_row. The active slot bank is untouched.
- frame_start during SCAN or COPY aborts to IDLE and clears the active slot bank.
- Pixel resolve: a valid slot s matches when (pix_x - x_s), computed in X_W+1 bits, is non-negative and less than SPR_W.
- Priority: the lowest matching slot wins, which is the lowest table index.
- No match gives hit=0, with all other pixel outputs 0.

## Timing
- Reset: all outputs are 0, the FSM is in IDLE, and all slots and both tables are invalid or zero.
- Scan latency: busy rises the cycle after line_start. Scan duration is NUM_SPRITES+1 cycles (NUM_SPRITES SCAN cycles plus COPY), then busy falls. The new slots are visible for pixel lookup on the cycle after COPY.
- The scan must fit inside hblank (1280-pixel timing: 408 cycles).
- Pixel path: one register stage. The hit, spr_idx, spr_char, rel_x and rel_y outputs correspond to the pix_x sampled on the previous edge.
- overflow is set on the edge following the offending SCAN cycle.

## Configuration
- SPRITE_MIRROR_EN defined:
  - char[7] is the horizontal-mirror flag.
  - rel_x = SPR_W-1-(pix_x-x) when the flag is set.
  - spr_char[7] is forced to 0.
- SPRITE_MIRROR_EN undefined:
  - char[7] is an ordinary char bit, passed through unchanged.
  - rel_x is never mirrored.

## Structure
- Package ppu_pkg holds:
  - entry field offsets and widths;
  - the slot record type {valid, idx, x, char, dy};
  - the FSM state enum {IDLE, SCAN, COPY}.
- Sub-module sprite_slot_match, instantiated SLOTS times, performs one slot's x-range compare and computes rel_x, including mirroring.
- A priority encoder in the top level selects the winner.

## Test plan
- Basic hit: write entry 0 = {char 0x05, y 100, x 200}, pulse frame_start, line_start with eval_row 110, then sweep pix_x. Expect hit=1 only for pix_x 200..263, with rel_x 0..63, rel_y 10, spr_idx 0.
- Priority: entries 1 and 3 overlap at x 300 on row 50. Expect spr_idx=1.
- Overflow: SLOTS+1 entries all on row 20. Expect the lowest SLOTS entries to be resolved, the last entry dropped, and overflow=1. The next frame_start clears overflow.
- Commit hazard: wr_en to entry 0 in the same cycle as frame_start. Expect the old entry 0 to render this frame and the new value next frame.
- Boundary: y=0 with eval_row=SPR_H-1 hits; eval_row=SPR_H misses. Entry x = 2^X_W-SPR_W/2 produces no wrap-around hit at pix_x 0.
- Mirror (macro defined): char 0x85 at x 200, pix_x 200. Expect rel_x=63 and spr_char=0x05.
